interpolador: RTL

- Linear-interpolating upsampler: the expanding counterpart of the team's 14-sample averaging decimator.
- Accepts one N-bit sample per input handshake and emits L output samples stepping linearly from the previous accepted sample to the new one. The last emitted sample equals the new sample exactly.
- Sits upstream of the averager and drives its sample/enable stream; out_valid & out_ready is the averager's en.

---
 rtl/interpolador.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/interpolador.sv
// interpolador: linear-interpolating upsampler.
// Each accepted N-bit sample produces a burst of L outputs that step linearly
// from the previously accepted sample to the new one. The last output of a
// burst equals the new sample exactly.
// Optional build macro INTERP_ZOH_EN adds a zoh input. When zoh is high at
// accept, every output of that burst equals the new sample (zero-order hold).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   zoh        (INTERP_ZOH_EN only) zero-order-hold select, sampled at accept
//   in_valid   input sample offered
//   in         input sample
//   in_ready   block can accept a sample this cycle (combinational)
//   out_valid  output sample valid
//   out        interpolated sample
//   out_ready  consumer accepts out this cycle
//   busy       high while a burst is running
module interpolador #(
  parameter int unsigned N  = 4,
  parameter int unsigned L  = 14,
  parameter int unsigned CW = 4
) (
  input  logic         clk,
  input  logic         reset,
`ifdef INTERP_ZOH_EN
  input  logic         zoh,
`endif
  input  logic         in_valid,
  input  logic [N-1:0] in,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Arithmetic width: wide enough for delta, quotient and accumulator sums.
  localparam int unsigned DW = N + CW + 2;
  localparam logic signed [DW-1:0] LS = DW'(L);
  localparam logic [CW-1:0]        KL = CW'(L);

  logic [0:0]           state, state_n;
  logic [N-1:0]         x_prev, x_prev_n;
  logic [N-1:0]         x_cap, x_cap_n;
  logic [N-1:0]         y_n;
  logic signed [DW-1:0] acc_r, acc_n;
  logic signed [DW-1:0] q_r, q_n;
  logic signed [DW-1:0] r_r, r_n;
  logic [CW-1:0]        k, k_n;
  logic                 valid_n, busy_n;

  logic [N-1:0]         base_c;
  logic signed [DW-1:0] delta_c, qt_c, rt_c, q_c, r_c;
  logic signed [DW-1:0] acc_step_c;
  logic                 wrap_c, last_c, load_c;

  // Last handshake of a burst: the only RUN cycle where a new sample is taken.
  assign last_c   = (state == RUN) && out_ready && (k == KL);
  assign in_ready = !reset && ((state == IDLE) || last_c);

  // A new burst starts from the captured sample when chaining without a bubble.
  assign base_c  = (state == RUN) ? x_cap : x_prev;
  assign delta_c = $signed(DW'(in)) - $signed(DW'(base_c));

  // Floor division by constant L: fix up truncating divide for negative delta.
  always_comb begin
    qt_c = delta_c / LS;
    rt_c = delta_c % LS;
    if (rt_c < 0) begin
      q_c = qt_c - DW'(1);
      r_c = rt_c + LS;
    end else begin
      q_c = qt_c;
      r_c = rt_c;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    x_prev_n = x_prev;
    x_cap_n  = x_cap;
    y_n      = out;
    acc_n    = acc_r;
    q_n      = q_r;
    r_n      = r_r;
    k_n      = k;
    valid_n  = out_valid;
    busy_n   = busy;
    load_c   = 1'b0;

    acc_step_c = acc_r + r_r;
    wrap_c     = (acc_step_c >= LS);

    case (state)
      IDLE: begin
        if (in_valid) load_c = 1'b1;
      end
      RUN: begin
        if (out_ready) begin
          if (k == KL) begin
            x_prev_n = x_cap;
            if (in_valid) begin
              load_c = 1'b1;
            end else begin
              state_n = IDLE;
              valid_n = 1'b0;
              busy_n  = 1'b0;
            end
          end else begin
            k_n   = k + CW'(1);
            acc_n = wrap_c ? (acc_step_c - LS) : acc_step_c;
            y_n   = N'($signed(DW'(out)) + q_r + (wrap_c ? DW'(1) : DW'(0)));
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Accept: the first step has acc = r < L, so y_1 = base + q with no carry.
    if (load_c) begin
      state_n = RUN;
      valid_n = 1'b1;
      busy_n  = 1'b1;
      x_cap_n = in;
      k_n     = CW'(1);
      q_n     = q_c;
      r_n     = r_c;
      acc_n   = r_c;
      y_n     = N'($signed(DW'(base_c)) + q_c);
`ifdef INTERP_ZOH_EN
      if (zoh) begin
        q_n   = '0;
        r_n   = '0;
        acc_n = '0;
        y_n   = in;
      end
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x_prev    <= '0;
      x_cap     <= '0;
      out       <= '0;
      acc_r     <= '0;
      q_r       <= '0;
      r_r       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      x_prev    <= x_prev_n;
      x_cap     <= x_cap_n;
      out       <= y_n;
      acc_r     <= acc_n;
      q_r       <= q_n;
      r_r       <= r_n;
      k         <= k_n;
      out_valid <= valid_n;
      busy      <= busy_n;
    end
  end

endmodule
